// File: rtl/sw_word_loader_pkg.sv
// sw_word_loader_pkg
// Shared helpers for the switch word loader: chunk count and select-width
// derivation, plus a parameter sanity predicate used at elaboration time.
// No ports (package).
package sw_word_loader_pkg;

    // Number of CHUNK-bit slices that make up a WIDTH-bit word.
    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width; a single-chunk word still gets a 1-bit select so
    // the ports never collapse to zero width.
    function automatic int sel_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

    // True when the parameter set describes a buildable loader.
    function automatic bit params_ok(input int width, input int chunk, input int deb);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0) && (deb >= 1);
    endfunction

endpackage

// File: rtl/sw_word_loader_key_debounce.sv
// key_debounce
// Brings an asynchronous active-high key into the clock domain, debounces
// it and emits a one-cycle strobe on each accepted press.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   key_i  - raw key level, asynchronous to clk
//   stb_o  - one-cycle pulse on the accepted 0->1 transition
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic stb_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronised key disagrees with the
    // accepted level; once it has seen DEB_CYCLES disagreeing cycles and the
    // key still disagrees, the accepted level flips.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Two-flop synchroniser, debounce state and a delayed copy of the
    // accepted level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // Press edge only; releases never strobe.
    assign stb_o = level_q & ~prev_q;

endmodule

// File: rtl/sw_word_loader.sv
// sw_word_loader
// Assembles a WIDTH-bit operand word from CHUNK-bit switch slices, written
// on each debounced press of the load key, either at an explicit chunk index
// or at an auto-incrementing pointer.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   sw_data     - switch slice to write
//   sel         - chunk index for manual writes
//   view_sel    - chunk index shown on view_out
//   load_key    - raw load key, active-high, asynchronous
//   auto_mode   - 1: write at pointer and advance; 0: write at sel
//   word_out    - assembled word
//   view_out    - selected chunk of word_out (0 if out of range)
//   ptr_out     - auto-mode chunk pointer
//   word_valid  - one-cycle pulse after the last chunk is written in auto mode
module sw_word_loader
    import sw_word_loader_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int CHUNK      = 8,
    parameter  int DEB_CYCLES = 4,
    localparam int NCHUNK     = num_chunks(WIDTH, CHUNK),
    localparam int SELW       = sel_width(num_chunks(WIDTH, CHUNK))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CHUNK-1:0] sw_data,
    input  logic [SELW-1:0]  sel,
    input  logic [SELW-1:0]  view_sel,
    input  logic             load_key,
    input  logic             auto_mode,
    output logic [WIDTH-1:0] word_out,
    output logic [CHUNK-1:0] view_out,
    output logic [SELW-1:0]  ptr_out,
    output logic             word_valid
);

    if (!params_ok(WIDTH, CHUNK, DEB_CYCLES)) begin : g_bad_params
        $error("sw_word_loader: WIDTH must be a multiple of CHUNK and DEB_CYCLES >= 1");
    end

    localparam logic [SELW-1:0] LAST_IDX = SELW'(NCHUNK - 1);
    localparam logic [SELW:0]   NCHUNK_W = (SELW + 1)'(NCHUNK);

    logic             load_stb;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [SELW-1:0]  ptr_q;
    logic [SELW-1:0]  ptr_d;
    logic             valid_q;
    logic             valid_d;
    logic             wr_en;
    logic [SELW-1:0]  wr_idx;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_load_key (
        .clk  (clk),
        .reset(reset),
        .key_i(load_key),
        .stb_o(load_stb)
    );

    // Write decode. The pointer is forced to 0 whenever auto mode is off so
    // that re-entering auto mode always starts at chunk 0; manual writes to
    // a non-existent chunk are silently dropped. With a single chunk the
    // index is irrelevant and every write lands in chunk 0.
    always_comb begin
        word_d  = word_q;
        ptr_d   = auto_mode ? ptr_q : '0;
        valid_d = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (load_stb) begin
            if (auto_mode) begin
                wr_en = 1'b1;
                if (ptr_q == LAST_IDX) begin
                    ptr_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end else begin
                wr_idx = sel;
                wr_en  = (NCHUNK == 1) || ({1'b0, sel} < NCHUNK_W);
            end
        end
        for (int k = 0; k < NCHUNK; k++) begin
            if (wr_en && ((NCHUNK == 1) || (wr_idx == k[SELW-1:0]))) begin
                word_d[k*CHUNK +: CHUNK] = sw_data;
            end
        end
    end

    // Word, pointer and completion-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    // Readback mux; an out-of-range view index shows zero.
    always_comb begin
        view_out = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (view_sel == k[SELW-1:0]) begin
                view_out = word_q[k*CHUNK +: CHUNK];
            end
        end
    end

    assign word_out   = word_q;
    assign ptr_out    = ptr_q;
    assign word_valid = valid_q;

endmodule

// File: tb/tb_sw_word_loader.sv
// tb_sw_word_loader
// Self-checking bench for sw_word_loader built as a 24-bit word of three
// 8-bit chunks, so that an index of 3 is representable but out of range.
module tb_sw_word_loader;

    localparam int W   = 24;
    localparam int C   = 8;
    localparam int DEB = 4;
    localparam int NC  = W / C;
    localparam int LAT = DEB + 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [C-1:0] sw_data;
    logic [1:0]   sel;
    logic [1:0]   view_sel;
    logic         load_key;
    logic         auto_mode;
    logic [W-1:0] word_out;
    logic [C-1:0] view_out;
    logic [1:0]   ptr_out;
    logic         word_valid;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference state: the word as bytes and the auto-mode pointer.
    logic [W-1:0] mWord = '0;
    int           mPtr = 0;

    sw_word_loader #(
        .WIDTH(W),
        .CHUNK(C),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_data   (sw_data),
        .sel       (sel),
        .view_sel  (view_sel),
        .load_key  (load_key),
        .auto_mode (auto_mode),
        .word_out  (word_out),
        .view_out  (view_out),
        .ptr_out   (ptr_out),
        .word_valid(word_valid)
    );

    always #5 clk = ~clk;

    // Full press: key sampled high at edge 0 and held for 'hold' edges.
    // sw_data holds junk until after edge 2 so the write must use the value
    // present at the strobe edge. Checked every cycle, then for a tail after
    // release to show the release writes nothing.
    task automatic do_press(input logic [7:0] data, input logic [1:0] s,
                            input logic am, input int hold, input string tag);
        logic [W-1:0] newW;
        int           oldP;
        int           newP;
        logic         v;
        if (!am) mPtr = 0;
        oldP = mPtr;
        newP = mPtr;
        newW = mWord;
        v    = 1'b0;
        if (am) begin
            newW[mPtr*C +: C] = data;
            v    = (mPtr == NC - 1);
            newP = (mPtr + 1) % NC;
        end else if (int'(s) < NC) begin
            newW[int'(s)*C +: C] = data;
        end
        @(negedge clk);
        sw_data   = ~data;
        sel       = s;
        auto_mode = am;
        load_key  = 1'b1;
        for (int i = 0; i < hold + 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            nCompared++;
            if (word_out !== ((i >= LAT) ? newW : mWord)) begin
                nMismatched++;
                $display("FAIL %s word edge%0d: got %h want %h", tag, i, word_out,
                         (i >= LAT) ? newW : mWord);
            end
            nCompared++;
            if (int'(ptr_out) != ((i >= LAT) ? newP : oldP)) begin
                nMismatched++;
                $display("FAIL %s ptr edge%0d: got %0d want %0d", tag, i, ptr_out,
                         (i >= LAT) ? newP : oldP);
            end
            nCompared++;
            if (word_valid !== ((i == LAT) ? v : 1'b0)) begin
                nMismatched++;
                $display("FAIL %s valid edge%0d: got %b want %b", tag, i, word_valid,
                         (i == LAT) ? v : 1'b0);
            end
            if (i == 2) sw_data = data;
            if (i == hold - 1) load_key = 1'b0;
        end
        mWord = newW;
        mPtr  = newP;
    endtask

    task automatic check_view(input string tag);
        logic [C-1:0] exp;
        for (int vs = 0; vs < 4; vs++) begin
            view_sel = 2'(vs);
            #1;
            exp = (vs < NC) ? mWord[vs*C +: C] : '0;
            nCompared++;
            if (view_out !== exp) begin
                nMismatched++;
                $display("FAIL %s view%0d: got %h want %h", tag, vs, view_out, exp);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        view_sel = 2'd0;
        #1;
        nCompared++;
        if (word_out !== '0 || ptr_out !== 2'd0 || word_valid !== 1'b0 || view_out !== '0) begin
            nMismatched++;
            $display("FAIL %s reset: got word=%h ptr=%0d valid=%b view=%h want all 0",
                     tag, word_out, ptr_out, word_valid, view_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_key = 1'b1; auto_mode = 1'b1; sw_data = 8'hA5;
        sel = 2'd1; view_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        load_key = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zero("initial");
        mWord = '0; mPtr = 0;
    endtask

    task automatic test_manual();
        do_press(8'h34, 2'd0, 1'b0, 10, "manual0");
        do_press(8'h12, 2'd1, 1'b0, 10, "manual1");
        do_press(8'h5C, 2'd2, 1'b0, 10, "manual2");
        do_press(8'hFF, 2'd3, 1'b0, 10, "manual_oob");
        check_view("view_manual");
    endtask

    task automatic test_debounce();
        @(negedge clk);
        sw_data = 8'h77; sel = 2'd0; auto_mode = 1'b0; load_key = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        load_key = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            nCompared++;
            if (word_out !== mWord) begin
                nMismatched++;
                $display("FAIL glitch word: got %h want %h", word_out, mWord);
            end
        end
        do_press(8'h9A, 2'd0, 1'b0, 40, "long_hold");
    endtask

    task automatic test_auto();
        do_press(8'hEF, 2'd3, 1'b1, 10, "auto0");
        do_press(8'hBE, 2'd0, 1'b1, 10, "auto1");
        do_press(8'hAD, 2'd1, 1'b1, 10, "auto2_wrap");
        do_press(8'h11, 2'd2, 1'b1, 10, "auto3_again");
        check_view("view_auto");
    endtask

    task automatic test_drop_auto();
        do_press(8'h21, 2'd0, 1'b1, 9, "drop_a");
        @(negedge clk);
        auto_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mPtr = 0;
        nCompared++;
        if (ptr_out !== 2'd0 || word_out !== mWord) begin
            nMismatched++;
            $display("FAIL drop_auto: got ptr=%0d word=%h want ptr=0 word=%h",
                     ptr_out, word_out, mWord);
        end
        do_press(8'h42, 2'd0, 1'b1, 9, "drop_restart");
    endtask

    task automatic test_mid_reset();
        do_press(8'h01, 2'd0, 1'b1, 9, "mid_a");
        do_press(8'h02, 2'd0, 1'b1, 9, "mid_b");
        @(negedge clk);
        sw_data = 8'hC3; load_key = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; load_key = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mWord = '0; mPtr = 0;
        check_zero("mid_reset");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nCompared++;
            if (word_out !== '0 || word_valid !== 1'b0) begin
                nMismatched++;
                $display("FAIL mid_reset_hold: got word=%h valid=%b want 0", word_out, word_valid);
            end
        end
        do_press(8'h66, 2'd2, 1'b1, 9, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            do_press(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom_range(9, 14), $sformatf("rand%0d", n));
        end
        check_view("view_rand");
    endtask

    initial begin
        test_reset();
        test_manual();
        test_debounce();
        test_auto();
        test_drop_auto();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
